legofpga_bringup_seq: RTL and testbench



---
 rtl/legofpga_bringup_seq.sv | 215 +++++++++++++++++++++
 tb/tb_legofpga_bringup_seq.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/legofpga_bringup_seq.sv
// legofpga_bringup_seq
//   Bring-up sequencer for the LegoFPGA MAC/PHY block (125 MHz domain).
//   Waits for MMCM lock, then holds the PHY in reset and waits for it to settle.
//   It then pulses start_config and streams NUM_CMDS command nibbles over a
//   valid/ready interface. Finally it debounces link_up and reports done/error.
//
// Optional feature macro: LEGOFPGA_BRINGUP_RETRY_EN
//   defined   : an ERROR entry with retry_cnt < MAX_RETRY restarts from IDLE,
//               increments retry_cnt and pulses bringup_error for one cycle.
//   undefined : ERROR is terminal until sys_rst, retry_cnt stays 0.
//
// Ports:
//   clk_125        in   sole clock
//   sys_rst        in   synchronous active-high reset
//   mmcm_locked_i  in   MMCM lock status
//   link_up        in   PHY/MAC link status
//   phy_rst_n      out  PHY reset (active-low)
//   start_config   out  one-cycle configuration start pulse
//   control_data   out  [3:0] command nibble
//   control_valid  out  command valid
//   control_ready  in   command accept
//   bringup_done   out  sequence complete, link qualified
//   bringup_error  out  timeout or link loss
//   state_dbg      out  [2:0] current state encoding
//   retry_cnt      out  [1:0] retries consumed
// All outputs are registered.
module legofpga_bringup_seq #(
  parameter int unsigned           PHY_RST_CYCLES  = 1250000,
  parameter int unsigned           PHY_WAIT_CYCLES = 625000,
  parameter int unsigned           NUM_CMDS        = 4,
  parameter logic [4*NUM_CMDS-1:0] CMD_LIST        = 16'h4321,
  parameter int unsigned           CMD_TIMEOUT     = 65535,
  parameter int unsigned           LINK_TIMEOUT    = 12500000,
  parameter int unsigned           MAX_RETRY       = 3
) (
  input  logic       clk_125,
  input  logic       sys_rst,
  input  logic       mmcm_locked_i,
  input  logic       link_up,
  output logic       phy_rst_n,
  output logic       start_config,
  output logic [3:0] control_data,
  output logic       control_valid,
  input  logic       control_ready,
  output logic       bringup_done,
  output logic       bringup_error,
  output logic [2:0] state_dbg,
  output logic [1:0] retry_cnt
);

  localparam int unsigned MAX_A = (PHY_RST_CYCLES > PHY_WAIT_CYCLES) ? PHY_RST_CYCLES : PHY_WAIT_CYCLES;
  localparam int unsigned MAX_B = (CMD_TIMEOUT > LINK_TIMEOUT) ? CMD_TIMEOUT : LINK_TIMEOUT;
  localparam int unsigned MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W = $clog2(MAX_T) + 1;

  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(PHY_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(CMD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LINK_LAST  = CNT_W'(LINK_TIMEOUT - 1);
  localparam logic [3:0]       IDX_LAST   = 4'(NUM_CMDS - 1);

  // Command list zero-padded to the 16-entry maximum so any 4-bit index is in range.
  localparam logic [63:0] CMD_PAD = 64'(CMD_LIST);

`ifdef LEGOFPGA_BRINGUP_RETRY_EN
  localparam bit RETRY_ON = 1'b1;
`else
  localparam bit RETRY_ON = 1'b0;
`endif
  // A limit of zero disables retries entirely (retry_cnt never leaves 0).
  localparam logic [1:0] RETRY_LIM = RETRY_ON ? 2'(MAX_RETRY) : 2'd0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PHY_RST  = 3'd1,
    ST_PHY_WAIT = 3'd2,
    ST_START    = 3'd3,
    ST_CMD      = 3'd4,
    ST_LINK     = 3'd5,
    ST_DONE     = 3'd6,
    ST_ERROR    = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       deb_q, deb_d;
  logic [3:0]       idx_q, idx_d;
  logic [1:0]       retry_q, retry_d;
  logic             phy_rst_n_q, phy_rst_n_d;
  logic             start_config_q, start_config_d;
  logic [3:0]       control_data_q, control_data_d;
  logic             control_valid_q, control_valid_d;
  logic             bringup_done_q, bringup_done_d;
  logic             bringup_error_q, bringup_error_d;
  logic             err_pulse;
  logic             xfer;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    deb_d     = deb_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    err_pulse = 1'b0;
    xfer      = (state_q == ST_CMD) && control_ready;

    case (state_q)
      ST_IDLE: begin
        if (mmcm_locked_i) state_d = ST_PHY_RST;
      end
      ST_PHY_RST: begin
        if (cnt_q == RST_LAST) state_d = ST_PHY_WAIT;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_PHY_WAIT: begin
        if (cnt_q == WAIT_LAST) state_d = ST_START;
        else                    cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_START: begin
        state_d = ST_CMD;
      end
      ST_CMD: begin
        // cnt_q is the stall counter here; it restarts on every accepted beat.
        if (xfer) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) state_d = ST_LINK;
          else                   idx_d   = idx_q + 4'd1;
        end else if (cnt_q == STALL_LAST) begin
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LINK: begin
        // Debounce completion takes priority over the overall timeout.
        deb_d = link_up ? deb_q + 4'd1 : '0;
        if (link_up && (deb_q == 4'hF))  state_d = ST_DONE;
        else if (cnt_q == LINK_LAST)     state_d = ST_ERROR;
        else                             cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_DONE: begin
        deb_d = link_up ? '0 : deb_q + 4'd1;
        if (!link_up && (deb_q == 4'hF)) state_d = ST_ERROR;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: state_d = ST_IDLE;
    endcase

    // Lock loss overrides every in-flight transition.
    if (!mmcm_locked_i && (state_q != ST_IDLE) && (state_q != ST_ERROR))
      state_d = ST_IDLE;

    // Redirect an ERROR entry into a restart while retries remain.
    if ((state_d == ST_ERROR) && (state_q != ST_ERROR) && (retry_q != RETRY_LIM)) begin
      state_d   = ST_IDLE;
      retry_d   = retry_q + 2'd1;
      err_pulse = 1'b1;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
      deb_d = '0;
    end
    if (state_d != ST_CMD) idx_d = '0;

    // Outputs are decoded from the next state so they line up with state_dbg.
    phy_rst_n_d     = (state_d == ST_PHY_WAIT) || (state_d == ST_START) ||
                      (state_d == ST_CMD) || (state_d == ST_LINK) || (state_d == ST_DONE);
    start_config_d  = (state_d == ST_START);
    control_valid_d = (state_d == ST_CMD);
    control_data_d  = (state_d == ST_CMD) ? CMD_PAD[{idx_d, 2'b00} +: 4] : '0;
    bringup_done_d  = (state_d == ST_DONE);
    bringup_error_d = (state_d == ST_ERROR) || err_pulse;
  end

  always_ff @(posedge clk_125) begin
    if (sys_rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      deb_q           <= '0;
      idx_q           <= '0;
      retry_q         <= '0;
      phy_rst_n_q     <= 1'b0;
      start_config_q  <= 1'b0;
      control_data_q  <= '0;
      control_valid_q <= 1'b0;
      bringup_done_q  <= 1'b0;
      bringup_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      deb_q           <= deb_d;
      idx_q           <= idx_d;
      retry_q         <= retry_d;
      phy_rst_n_q     <= phy_rst_n_d;
      start_config_q  <= start_config_d;
      control_data_q  <= control_data_d;
      control_valid_q <= control_valid_d;
      bringup_done_q  <= bringup_done_d;
      bringup_error_q <= bringup_error_d;
    end
  end

  assign phy_rst_n     = phy_rst_n_q;
  assign start_config  = start_config_q;
  assign control_data  = control_data_q;
  assign control_valid = control_valid_q;
  assign bringup_done  = bringup_done_q;
  assign bringup_error = bringup_error_q;
  assign state_dbg     = state_q;
  assign retry_cnt     = retry_q;

endmodule

// File: tb/tb_legofpga_bringup_seq.sv
// Testbench for legofpga_bringup_seq with short timing parameters.
// Expected events (start pulse, accepted beats, done/error rising edges) are
// queued by the stimulus; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_legofpga_bringup_seq;

  logic       clk_125 = 1'b0;
  logic       sys_rst = 1'b1;
  logic       mmcm_locked_i = 1'b0;
  logic       link_up = 1'b0;
  logic       control_ready = 1'b0;
  logic       phy_rst_n;
  logic       start_config;
  logic [3:0] control_data;
  logic       control_valid;
  logic       bringup_done;
  logic       bringup_error;
  logic [2:0] state_dbg;
  logic [1:0] retry_cnt;

  always #4 clk_125 = ~clk_125;

  legofpga_bringup_seq #(
    .PHY_RST_CYCLES (10),
    .PHY_WAIT_CYCLES(5),
    .NUM_CMDS       (3),
    .CMD_LIST       (12'h3A5),
    .CMD_TIMEOUT    (20),
    .LINK_TIMEOUT   (50),
    .MAX_RETRY      (3)
  ) dut (
    .clk_125      (clk_125),
    .sys_rst      (sys_rst),
    .mmcm_locked_i(mmcm_locked_i),
    .link_up      (link_up),
    .phy_rst_n    (phy_rst_n),
    .start_config (start_config),
    .control_data (control_data),
    .control_valid(control_valid),
    .control_ready(control_ready),
    .bringup_done (bringup_done),
    .bringup_error(bringup_error),
    .state_dbg    (state_dbg),
    .retry_cnt    (retry_cnt)
  );

  localparam int EV_START = 0;
  localparam int EV_XFER  = 1;
  localparam int EV_DONE  = 2;
  localparam int EV_ERR   = 3;

  typedef struct {
    int         kind;
    logic [3:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  bit  flap_en = 1'b0;
  int  flap_cnt = 0;
  logic done_prev = 1'b0;
  logic err_prev  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [3:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic expect_ev(input int kind, input logic [3:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d data 0x%0h, expected none", kind, data);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      if (e.kind == EV_XFER && kind == EV_XFER) check("xfer_data", 32'(data), 32'(e.data));
    end
  endtask

  // Monitor: samples on negedge, away from the active edge.
  always @(negedge clk_125) begin
    if (!sys_rst) begin
      if (start_config)                  expect_ev(EV_START, 4'h0);
      if (control_valid && control_ready) expect_ev(EV_XFER, control_data);
      if (bringup_done && !done_prev)    expect_ev(EV_DONE, 4'h0);
      if (bringup_error && !err_prev)    expect_ev(EV_ERR, 4'h0);
    end
    done_prev = bringup_done;
    err_prev  = bringup_error;
  end

  task automatic tick();
    @(posedge clk_125);
    #1;
    if (flap_en) begin
      flap_cnt++;
      if (flap_cnt == 8) begin
        flap_cnt = 0;
        link_up  = ~link_up;
      end
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    tick();
    tick();
    exp_q.delete();
    sys_rst = 1'b0;
  endtask

  task automatic wait_for(input logic [2:0] st, input int budget);
    int n = 0;
    while (state_dbg !== st) begin
      if (n >= budget) begin
        n_tests++;
        n_fail++;
        $display("FAIL wait_state: got state %0d, expected %0d within %0d cycles", state_dbg, st, budget);
        return;
      end
      tick();
      n++;
    end
  endtask

  task automatic count_in(input logic [2:0] st, input int budget, output int n);
    n = 0;
    while (state_dbg === st) begin
      if (n >= budget) begin
        n_tests++;
        n_fail++;
        $display("FAIL state_stuck: state %0d still held after %0d cycles", st, budget);
        return;
      end
      n++;
      tick();
    end
  endtask

  task automatic drained(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({state_dbg, phy_rst_n, start_config, control_valid, control_data,
                bringup_done, bringup_error, retry_cnt});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // ---------------- nominal ----------------
    mmcm_locked_i = 1'b1;
    link_up       = 1'b1;
    control_ready = 1'b1;
    sys_rst       = 1'b1;
    tick();
    tick();
    check("reset_outputs", out_vec(), 32'd0);
    push_ev(EV_START, 4'h0);
    push_ev(EV_XFER, 4'h5);
    push_ev(EV_XFER, 4'hA);
    push_ev(EV_XFER, 4'h3);
    push_ev(EV_DONE, 4'h0);
    sys_rst = 1'b0;
    tick();
    check("nom_state_phy_rst", 32'(state_dbg), 32'd1);
    check("nom_phy_rst_n_low", 32'(phy_rst_n), 32'd0);
    count_in(3'd1, 100, n);
    check("nom_phy_rst_cycles", 32'(n), 32'd10);
    check("nom_phy_rst_n_high", 32'(phy_rst_n), 32'd1);
    count_in(3'd2, 100, n);
    check("nom_phy_wait_cycles", 32'(n), 32'd5);
    check("nom_start_pulse", 32'(start_config), 32'd1);
    tick();
    check("nom_start_cleared", 32'({state_dbg, start_config}), 32'({3'd4, 1'b0}));
    count_in(3'd4, 100, n);
    check("nom_cmd_cycles", 32'(n), 32'd3);
    check("nom_valid_after_cmd", 32'({control_valid, control_data}), 32'd0);
    count_in(3'd5, 100, n);
    check("nom_link_cycles", 32'(n), 32'd16);
    check("nom_done", 32'({state_dbg, bringup_done, bringup_error}), 32'({3'd6, 1'b1, 1'b0}));
    tick();
    drained("nom_events_drained");

    // ---------------- backpressure on cmd 1 ----------------
    do_reset();
    push_ev(EV_START, 4'h0);
    push_ev(EV_XFER, 4'h5);
    push_ev(EV_XFER, 4'hA);
    push_ev(EV_XFER, 4'h3);
    push_ev(EV_DONE, 4'h0);
    wait_for(3'd4, 100);
    tick();
    check("bp_cmd1_data", 32'(control_data), 32'hA);
    control_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("bp_hold", 32'({control_valid, control_data, bringup_error}), 32'({1'b1, 4'hA, 1'b0}));
    end
    control_ready = 1'b1;
    count_in(3'd4, 100, n);
    check("bp_cmd_tail_cycles", 32'(n), 32'd2);
    wait_for(3'd6, 100);
    check("bp_done", 32'({bringup_done, bringup_error}), 32'({1'b1, 1'b0}));
    tick();
    drained("bp_events_drained");

    // ---------------- lock loss during cmd 2 ----------------
    do_reset();
    push_ev(EV_START, 4'h0);
    push_ev(EV_XFER, 4'h5);
    push_ev(EV_XFER, 4'hA);
    push_ev(EV_XFER, 4'h3);   // beat in the lock-loss cycle is consumed
    push_ev(EV_START, 4'h0);
    push_ev(EV_XFER, 4'h5);
    push_ev(EV_XFER, 4'hA);
    push_ev(EV_XFER, 4'h3);
    push_ev(EV_DONE, 4'h0);
    wait_for(3'd4, 100);
    tick();
    tick();
    check("ll_cmd2_data", 32'(control_data), 32'h3);
    mmcm_locked_i = 1'b0;
    tick();
    check("ll_idle", 32'({state_dbg, control_valid, phy_rst_n, bringup_done}), 32'({3'd0, 1'b0, 1'b0, 1'b0}));
    mmcm_locked_i = 1'b1;
    wait_for(3'd4, 100);
    check("ll_replay_first", 32'(control_data), 32'h5);
    wait_for(3'd6, 100);
    tick();
    drained("ll_events_drained");

`ifndef LEGOFPGA_BRINGUP_RETRY_EN
    // ---------------- ready stuck low ----------------
    control_ready = 1'b0;
    do_reset();
    push_ev(EV_START, 4'h0);
    push_ev(EV_ERR, 4'h0);
    wait_for(3'd4, 100);
    count_in(3'd4, 100, n);
    check("stuck_stall_cycles", 32'(n), 32'd20);
    check("stuck_error", 32'({state_dbg, bringup_error, phy_rst_n, control_valid}),
          32'({3'd7, 1'b1, 1'b0, 1'b0}));
    tick();
    tick();
    check("stuck_terminal", 32'({state_dbg, retry_cnt}), 32'({3'd7, 2'd0}));
    drained("stuck_events_drained");

    // ---------------- link flapping ----------------
    control_ready = 1'b1;
    link_up       = 1'b1;
    flap_cnt      = 0;
    flap_en       = 1'b1;
    do_reset();
    push_ev(EV_START, 4'h0);
    push_ev(EV_XFER, 4'h5);
    push_ev(EV_XFER, 4'hA);
    push_ev(EV_XFER, 4'h3);
    push_ev(EV_ERR, 4'h0);
    wait_for(3'd5, 100);
    count_in(3'd5, 200, n);
    check("flap_link_cycles", 32'(n), 32'd50);
    check("flap_error", 32'({state_dbg, bringup_done, bringup_error}), 32'({3'd7, 1'b0, 1'b1}));
    flap_en = 1'b0;
    tick();
    drained("flap_events_drained");

    // ---------------- link loss after done ----------------
    link_up = 1'b1;
    do_reset();
    push_ev(EV_START, 4'h0);
    push_ev(EV_XFER, 4'h5);
    push_ev(EV_XFER, 4'hA);
    push_ev(EV_XFER, 4'h3);
    push_ev(EV_DONE, 4'h0);
    push_ev(EV_ERR, 4'h0);
    wait_for(3'd6, 100);
    link_up = 1'b0;
    repeat (15) tick();
    check("drop_15_still_done", 32'({state_dbg, bringup_done}), 32'({3'd6, 1'b1}));
    tick();
    check("drop_16_error", 32'({state_dbg, bringup_done, bringup_error}), 32'({3'd7, 1'b0, 1'b1}));
    tick();
    drained("drop_events_drained");
    link_up = 1'b1;
`else
    // ---------------- retry with ready stuck low ----------------
    control_ready = 1'b0;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      push_ev(EV_START, 4'h0);
      push_ev(EV_ERR, 4'h0);
    end
    tick();
    for (int r = 1; r <= 3; r++) begin
      wait_for(3'd0, 200);
      check("retry_pulse", 32'({bringup_error, retry_cnt}), 32'({1'b1, 2'(r)}));
      tick();
      check("retry_pulse_end", 32'(bringup_error), 32'd0);
    end
    wait_for(3'd7, 200);
    check("retry_terminal", 32'({bringup_error, retry_cnt, phy_rst_n}), 32'({1'b1, 2'd3, 1'b0}));
    tick();
    tick();
    check("retry_stays_error", 32'(state_dbg), 32'd7);
    drained("retry_events_drained");
`endif

    // ---------------- sys_rst in the middle of CMD ----------------
    control_ready = 1'b0;
    do_reset();
    push_ev(EV_START, 4'h0);
`ifdef LEGOFPGA_BRINGUP_RETRY_EN
    push_ev(EV_ERR, 4'h0);
    push_ev(EV_START, 4'h0);
    wait_for(3'd4, 100);
    wait_for(3'd0, 100);
    wait_for(3'd4, 100);
    check("midrst_retry_before", 32'(retry_cnt), 32'd1);
`else
    wait_for(3'd4, 100);
`endif
    tick();
    tick();
    check("midrst_in_cmd", 32'({state_dbg, control_valid, control_data}), 32'({3'd4, 1'b1, 4'h5}));
    drained("midrst_events_drained");
    sys_rst = 1'b1;
    tick();
    check("midrst_outputs", out_vec(), 32'd0);
    sys_rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
